// File: rtl/ls_mem_stage_if.sv
// Data-memory request/response bus between the load/store stage and memory.
interface ls_mem_stage_if #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned ADDR_W = 32
) ();

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [7:0]        mem_wstrb;
   logic              mem_ready;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rvalid, mem_rdata
   );

endinterface

// File: rtl/ls_mem_stage.sv
// Load/store stage: one bus transaction per load/store, load alignment and
// extension, pipeline stall while the transaction is outstanding.
module ls_mem_stage #(
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        ex_mem_ctl,
   input  logic [DATA_W-1:0] ex_addr,
   input  logic [DATA_W-1:0] ex_sdata,
   input  logic              ex_rd_ena,
   input  logic [4:0]        ex_rd_addr,
   input  logic              wb_stall,
   ls_mem_stage_if.master    bus,
   output logic [DATA_W-1:0] ls_wbdata,
   output logic              ls_stall,
   output logic              ls_misalign,
   output logic              ls_bus_err,
   output logic [4:0]        ls_rd_addr_forward,
   output logic [DATA_W-1:0] ls_rd_data_forward
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {StIdle, StReq, StResp, StHold} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0] result_q, result_d;

   // Request fields captured when leaving idle; upstream is not re-read later.
   logic              we_q, load_q, uns_q;
   logic [1:0]        size_q;
   logic [2:0]        off_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [7:0]        wstrb_q;

   logic              is_load, is_store, is_mem, misaligned, start, req, done, timeout;
   logic [7:0]        strb;
   logic [DATA_W-1:0] rshift, ext, ld_val;

   assign is_store = ex_mem_ctl[4] & ~ex_mem_ctl[3];
   assign is_load  = ex_mem_ctl[3] & ~ex_mem_ctl[4];
   assign is_mem   = is_store | is_load;
   assign start    = is_mem & ~misaligned;

   // Decode alignment and byte strobes of the presented op.
   always_comb begin
      misaligned = 1'b0;
      strb       = 8'h00;
      unique case (ex_mem_ctl[1:0])
         2'b00: begin misaligned = 1'b0;            strb = 8'h01 << ex_addr[2:0]; end
         2'b01: begin misaligned = ex_addr[0];      strb = 8'h03 << ex_addr[2:0]; end
         2'b10: begin misaligned = |ex_addr[1:0];   strb = 8'h0F << ex_addr[2:0]; end
         2'b11: begin misaligned = |ex_addr[2:0];   strb = 8'hFF;                 end
      endcase
   end

   // Align read data to bit 0 and extend to the register width.
   always_comb begin
      rshift = bus.mem_rdata >> {off_q, 3'b000};
      ext    = rshift;
      unique case (size_q)
         2'b00: ext = uns_q ? {{(DATA_W-8){1'b0}}, rshift[7:0]}
                            : {{(DATA_W-8){rshift[7]}}, rshift[7:0]};
         2'b01: ext = uns_q ? {{(DATA_W-16){1'b0}}, rshift[15:0]}
                            : {{(DATA_W-16){rshift[15]}}, rshift[15:0]};
         2'b10: ext = uns_q ? {{(DATA_W-32){1'b0}}, rshift[31:0]}
                            : {{(DATA_W-32){rshift[31]}}, rshift[31:0]};
         2'b11: ext = rshift;
      endcase
      ld_val = load_q ? ext : '0;
   end

   // Same-cycle ready+rvalid in REQ counts as a completed response.
   assign done    = ((state_q == StReq) & bus.mem_ready & bus.mem_rvalid) |
                    ((state_q == StResp) & bus.mem_rvalid);
   assign timeout = (cnt_q == CntW'(TIMEOUT));

   // Next-state and stage outputs.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      result_d    = result_q;
      req         = 1'b0;
      ls_stall    = 1'b0;
      ls_misalign = 1'b0;
      ls_bus_err  = 1'b0;
      ls_wbdata   = '0;
      unique case (state_q)
         StIdle: begin
            if (is_mem && misaligned) begin
               ls_misalign = 1'b1;
            end else if (start) begin
               ls_stall = 1'b1;
               cnt_d    = '0;
               state_d  = StReq;
            end
         end
         StReq, StResp: begin
            req      = (state_q == StReq);
            ls_stall = 1'b1;
            cnt_d    = cnt_q + CntW'(1);
            if (done) begin
               req       = 1'b0;
               result_d  = ld_val;
               ls_wbdata = ld_val;
               if (wb_stall) begin
                  state_d = StHold;
               end else begin
                  ls_stall = 1'b0;
                  state_d  = StIdle;
               end
            end else if (timeout) begin
               // Give up: release the pipeline with a zero result.
               req        = 1'b0;
               ls_stall   = 1'b0;
               ls_bus_err = 1'b1;
               state_d    = StIdle;
            end else if (state_q == StReq && bus.mem_ready) begin
               state_d = StResp;
            end
         end
         StHold: begin
            ls_wbdata = result_q;
            ls_stall  = wb_stall;
            if (!wb_stall) state_d = StIdle;
         end
      endcase
   end

   // State, timeout counter and result register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   // Capture the request when an op is accepted in idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q    <= 1'b0;
         load_q  <= 1'b0;
         uns_q   <= 1'b0;
         size_q  <= 2'b00;
         off_q   <= 3'b000;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= 8'h00;
      end else if (state_q == StIdle && start) begin
         we_q    <= is_store;
         load_q  <= is_load;
         uns_q   <= ex_mem_ctl[2];
         size_q  <= ex_mem_ctl[1:0];
         off_q   <= ex_addr[2:0];
         addr_q  <= {ex_addr[ADDR_W-1:3], 3'b000};
         wdata_q <= ex_sdata << {ex_addr[2:0], 3'b000};
         wstrb_q <= strb;
      end
   end

   assign bus.mem_req   = req;
   assign bus.mem_we    = req & we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_wstrb = wstrb_q;

   assign ls_rd_addr_forward = ex_rd_ena ? ex_rd_addr : 5'd0;
   assign ls_rd_data_forward = is_load ? ls_wbdata : ex_addr;

endmodule

// File: tb/tb_ls_mem_stage.sv
// Directed bench for ls_mem_stage: vector table plus hold/timeout/reset sequences.
module tb_ls_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  ex_mem_ctl;
   logic [63:0] ex_addr, ex_sdata;
   logic        ex_rd_ena;
   logic [4:0]  ex_rd_addr;
   logic        wb_stall;
   logic [63:0] ls_wbdata, ls_rd_data_forward;
   logic        ls_stall, ls_misalign, ls_bus_err;
   logic [4:0]  ls_rd_addr_forward;

   int checks = 0;
   int errors = 0;

   ls_mem_stage_if #(.DATA_W(64), .ADDR_W(32)) bus ();

   ls_mem_stage #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(255)) dut (
      .clk                (clk),
      .rst                (rst),
      .ex_mem_ctl         (ex_mem_ctl),
      .ex_addr            (ex_addr),
      .ex_sdata           (ex_sdata),
      .ex_rd_ena          (ex_rd_ena),
      .ex_rd_addr         (ex_rd_addr),
      .wb_stall           (wb_stall),
      .bus                (bus),
      .ls_wbdata          (ls_wbdata),
      .ls_stall           (ls_stall),
      .ls_misalign        (ls_misalign),
      .ls_bus_err         (ls_bus_err),
      .ls_rd_addr_forward (ls_rd_addr_forward),
      .ls_rd_data_forward (ls_rd_data_forward)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  ctl;
      logic [63:0] addr, sdata, rdata;
      int          rdy, rv;
      logic        rd_ena, busy, mis, we;
      logic [31:0] maddr;
      logic [7:0]  wstrb;
      logic [63:0] wdata, wb;
   } vec_t;

   vec_t v[14];

   function automatic vec_t mk(logic [4:0] ctl, logic [63:0] addr, logic [63:0] sdata,
                               logic [63:0] rdata, int rdy, int rv, logic rd_ena,
                               logic busy, logic mis, logic we, logic [31:0] maddr,
                               logic [7:0] wstrb, logic [63:0] wdata, logic [63:0] wb);
      vec_t r;
      r.ctl = ctl; r.addr = addr; r.sdata = sdata; r.rdata = rdata;
      r.rdy = rdy; r.rv = rv; r.rd_ena = rd_ena; r.busy = busy; r.mis = mis;
      r.we = we; r.maddr = maddr; r.wstrb = wstrb; r.wdata = wdata; r.wb = wb;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ex_mem_ctl = 5'd0; ex_addr = '0; ex_sdata = '0; ex_rd_ena = 1'b0; ex_rd_addr = 5'd0;
      wb_stall = 1'b0; bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
   endtask

   initial begin
      logic        is_ld;
      logic        early_bad;
      logic [63:0] r;

      // ctl, addr, sdata, rdata, rdy, rv, rd_ena, busy, mis, we, maddr, wstrb, wdata, wb
      v[0]  = mk(5'b00000, 64'h1234, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      v[1]  = mk(5'b11000, 64'h1000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      v[2]  = mk(5'b01000, 64'h80000003, 0, 64'h00000000_80000000, 2, 4, 1, 1, 0, 0,
                 32'h80000000, 8'h08, 0, 64'hFFFFFFFF_FFFFFF80);
      v[3]  = mk(5'b01100, 64'h80000003, 0, 64'h00000000_80000000, 1, 2, 0, 1, 0, 0,
                 32'h80000000, 8'h08, 0, 64'h80);
      v[4]  = mk(5'b10001, 64'h80000006, 64'hBEEF, 0, 1, 2, 0, 1, 0, 1,
                 32'h80000000, 8'hC0, 64'hBEEF0000_00000000, 0);
      v[5]  = mk(5'b01010, 64'h80000002, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
      v[6]  = mk(5'b01001, 64'h80000004, 0, 64'h00008001_00000000, 1, 1, 1, 1, 0, 0,
                 32'h80000000, 8'h30, 0, 64'hFFFFFFFF_FFFF8001);
      v[7]  = mk(5'b01110, 64'h80000004, 0, 64'hDEADBEEF_00000000, 3, 3, 1, 1, 0, 0,
                 32'h80000000, 8'hF0, 0, 64'hDEADBEEF);
      v[8]  = mk(5'b01010, 64'h80000004, 0, 64'hDEADBEEF_00000000, 1, 2, 1, 1, 0, 0,
                 32'h80000000, 8'hF0, 0, 64'hFFFFFFFF_DEADBEEF);
      v[9]  = mk(5'b01011, 64'h80000008, 0, 64'h01234567_89ABCDEF, 2, 3, 1, 1, 0, 0,
                 32'h80000008, 8'hFF, 0, 64'h01234567_89ABCDEF);
      v[10] = mk(5'b10011, 64'h10, 64'h11223344_55667788, 0, 1, 2, 1, 1, 0, 1,
                 32'h10, 8'hFF, 64'h11223344_55667788, 0);
      v[11] = mk(5'b10000, 64'h21, 64'hAB, 0, 2, 2, 1, 1, 0, 1,
                 32'h20, 8'h02, 64'hAB00, 0);
      v[12] = mk(5'b10001, 64'h31, 64'h5555, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
      v[13] = mk(5'b10010, 64'h44, 64'hCAFEF00D, 0, 1, 3, 1, 1, 0, 1,
                 32'h40, 8'hF0, 64'hCAFEF00D_00000000, 0);

      clear_inputs();
      rst = 1'b1;
      tick(); tick();
      chk("rst mem_req", 64'(bus.mem_req), 0);
      chk("rst stall", 64'(ls_stall), 0);
      chk("rst wbdata", ls_wbdata, 0);
      chk("rst misalign", 64'(ls_misalign), 0);
      chk("rst bus_err", 64'(ls_bus_err), 0);
      chk("rst mem_addr", 64'(bus.mem_addr), 0);
      rst = 1'b0;

      foreach (v[i]) begin
         is_ld = v[i].ctl[3] & ~v[i].ctl[4];
         tick();
         ex_mem_ctl = v[i].ctl; ex_addr = v[i].addr; ex_sdata = v[i].sdata;
         ex_rd_ena = v[i].rd_ena; ex_rd_addr = 5'(i + 1); bus.mem_rdata = v[i].rdata;
         #1;
         chk($sformatf("v%0d stall0", i), 64'(ls_stall), 64'(v[i].busy));
         chk($sformatf("v%0d misalign", i), 64'(ls_misalign), 64'(v[i].mis));
         chk($sformatf("v%0d rd_fwd", i), 64'(ls_rd_addr_forward),
             v[i].rd_ena ? 64'(i + 1) : 64'd0);
         if (!is_ld) chk($sformatf("v%0d data_fwd", i), ls_rd_data_forward, v[i].addr);
         if (v[i].busy) begin
            for (int c = 1; c <= v[i].rv; c++) begin
               tick();
               bus.mem_ready = (c == v[i].rdy); bus.mem_rvalid = (c == v[i].rv);
               #1;
               chk($sformatf("v%0d c%0d mem_req", i, c), 64'(bus.mem_req),
                   (c < v[i].rdy || (c == v[i].rdy && c < v[i].rv)) ? 64'd1 : 64'd0);
               if (c == 1) begin
                  chk($sformatf("v%0d we", i), 64'(bus.mem_we), 64'(v[i].we));
                  chk($sformatf("v%0d addr", i), 64'(bus.mem_addr), 64'(v[i].maddr));
                  chk($sformatf("v%0d wstrb", i), 64'(bus.mem_wstrb), 64'(v[i].wstrb));
                  chk($sformatf("v%0d wdata", i), bus.mem_wdata, v[i].wdata);
               end
               if (c < v[i].rv) begin
                  chk($sformatf("v%0d c%0d stall", i, c), 64'(ls_stall), 1);
               end else begin
                  chk($sformatf("v%0d done stall", i), 64'(ls_stall), 0);
                  chk($sformatf("v%0d wbdata", i), ls_wbdata, v[i].wb);
                  if (is_ld) chk($sformatf("v%0d data_fwd", i), ls_rd_data_forward, v[i].wb);
               end
            end
         end
         tick();
         clear_inputs();
         #1;
         chk($sformatf("v%0d after mem_req", i), 64'(bus.mem_req), 0);
         chk($sformatf("v%0d after stall", i), 64'(ls_stall), 0);
         chk($sformatf("v%0d after misalign", i), 64'(ls_misalign), 0);
      end

      // LD completing while write-back is stalled for three cycles.
      r = 64'hA5A5_5A5A_0F0F_F0F0;
      tick(); ex_mem_ctl = 5'b01011; ex_addr = 64'h8; ex_rd_ena = 1'b1; ex_rd_addr = 5'd7;
      bus.mem_rdata = r; #1;
      chk("hold c0 stall", 64'(ls_stall), 1);
      tick(); bus.mem_ready = 1'b1; #1;
      chk("hold c1 mem_req", 64'(bus.mem_req), 1);
      tick(); bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b1; wb_stall = 1'b1; #1;
      chk("hold c2 stall", 64'(ls_stall), 1);
      for (int c = 3; c <= 4; c++) begin
         tick(); bus.mem_rvalid = 1'b0; bus.mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD; #1;
         chk($sformatf("hold c%0d stall", c), 64'(ls_stall), 1);
         chk($sformatf("hold c%0d wbdata", c), ls_wbdata, r);
      end
      tick(); wb_stall = 1'b0; #1;
      chk("hold release stall", 64'(ls_stall), 0);
      chk("hold release wbdata", ls_wbdata, r);
      chk("hold release fwd", ls_rd_data_forward, r);
      tick(); clear_inputs(); #1;
      chk("hold idle stall", 64'(ls_stall), 0);
      chk("hold idle wbdata", ls_wbdata, 0);

      // Load whose request is never accepted.
      tick(); ex_mem_ctl = 5'b01010; ex_addr = 64'h100; #1;
      chk("to c0 stall", 64'(ls_stall), 1);
      early_bad = 1'b0;
      for (int c = 1; c <= 255; c++) begin
         tick();
         if (ls_bus_err !== 1'b0 || ls_stall !== 1'b1 || bus.mem_req !== 1'b1) early_bad = 1'b1;
      end
      chk("to waiting", 64'(early_bad), 0);
      tick();
      chk("to bus_err", 64'(ls_bus_err), 1);
      chk("to stall", 64'(ls_stall), 0);
      chk("to wbdata", ls_wbdata, 0);
      tick(); clear_inputs(); #1;
      chk("to pulse end", 64'(ls_bus_err), 0);
      chk("to idle mem_req", 64'(bus.mem_req), 0);

      // Reset while a request is outstanding; a late response is ignored.
      tick(); ex_mem_ctl = 5'b01011; ex_addr = 64'h8; #1;
      tick();
      chk("rstreq mem_req", 64'(bus.mem_req), 1);
      rst = 1'b1; clear_inputs();
      tick(); rst = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h1111; #1;
      chk("rstreq after mem_req", 64'(bus.mem_req), 0);
      chk("rstreq after stall", 64'(ls_stall), 0);
      chk("rstreq after wbdata", ls_wbdata, 0);
      tick(); clear_inputs(); #1;
      chk("rstreq idle stall", 64'(ls_stall), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ls_mem_stage.md
Name: ls_mem_stage

Overview:
- Load/store execution stage between the ex-ls pipeline register and the ls-wb pipeline register.
- Issues one data-memory transaction per load or store over a request/response bus.
- Aligns and extends load data, and stalls the pipeline while a transaction is in flight.
- Produces the write-back value, the forwarding pair and the stall that feeds the ls-wb register's ls_valid input.

Parameters:
- DATA_W, 64, data/register width
- ADDR_W, 32, bus address width
- TIMEOUT, 255, maximum cycles waiting for a response before a bus error

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_mem_ctl  in  5  [4]=store, [3]=load, [2]=unsigned load, [1:0]=size (00 B, 01 H, 10 W, 11 D); [4] and [3] both set is illegal and treated as no-op
- ex_addr  in  DATA_W  effective address (exu result)
- ex_sdata  in  DATA_W  store data, right-aligned
- ex_rd_ena  in  1  destination write enable
- ex_rd_addr  in  5  destination register
- wb_stall  in  1  downstream cannot accept this cycle
- mem_req  out  1  request valid
- mem_we  out  1  1=write
- mem_addr  out  ADDR_W  ex_addr[ADDR_W-1:3], low 3 bits zero
- mem_wdata  out  DATA_W  store data shifted to byte lane
- mem_wstrb  out  8  byte strobes
- mem_ready  in  1  request accepted
- mem_rvalid  in  1  response valid (read data or write ack)
- mem_rdata  in  DATA_W  read data, 8-byte aligned
- ls_wbdata  out  DATA_W  extended load result; 0 for non-loads
- ls_stall  out  1  stage busy; hold upstream and downstream
- ls_misalign  out  1  misaligned access detected (1-cycle pulse)
- ls_bus_err  out  1  response timeout (1-cycle pulse)
- ls_rd_addr_forward  out  5  ex_rd_addr when ex_rd_ena else 0
- ls_rd_data_forward  out  DATA_W  ls_wbdata for loads, ex_addr otherwise

Behaviour:
- States: IDLE, REQ, RESP, HOLD. Reset: state=IDLE; all outputs 0; timeout counter 0; result register 0.
- IDLE, non-memory op: ls_stall=0, no bus activity, zero latency.
- IDLE, legal aligned load/store: ls_stall=1 combinationally. Go to REQ next edge; mem_req rises the cycle after the op is presented.
- Misaligned access (addr not a multiple of the size): ls_misalign=1 that cycle; no request; ls_stall=0; stay IDLE.
- REQ: mem_req=1 with stable addr/we/wdata/wstrb until mem_ready. On mem_ready, go to RESP.
- mem_ready and mem_rvalid in the same REQ cycle is treated as a completed response.
- RESP: mem_req=0. On mem_rvalid, capture the extended result into the result register.
  - If wb_stall=0: drop ls_stall this same cycle, drive ls_wbdata from the extended mem_rdata combinationally, go to IDLE.
  - If wb_stall=1: go to HOLD.
- HOLD: ls_stall=1; ls_wbdata=result register. The first cycle with wb_stall=0 drops ls_stall; go to IDLE.
- Load extraction: byte offset = ex_addr[2:0]; shift mem_rdata right by 8×offset. Extend from 8/16/32 bits by sign bit unless [2]=1 (zero-extend); D passes through.
- Store lanes: wdata = ex_sdata << 8×offset. wstrb is B=1<<off, H=3<<off, W=0xF<<off, D=0xFF.
- Timeout counter: cleared on entering REQ, increments in REQ/RESP. When it reaches TIMEOUT: ls_bus_err pulse, ls_wbdata=0, ls_stall=0, go to IDLE.
- Inputs from upstream are held stable by ls_stall; the FSM re-reads nothing after leaving IDLE.
- Pipeline flush does not abort an in-flight transaction; flush is applied by the ls-wb register.
- Reset in any state returns to IDLE next edge with mem_req=0. A pending response after reset is ignored.

Test Plan:
- ALU op, ex_mem_ctl=0, ex_addr=0x1234 -> ls_stall=0, mem_req never 1, ls_rd_data_forward=0x1234.
- LB, addr=0x80000003, unsigned=0, mem_rdata=0x00000000_80000000 (byte 3 = 0x80), ready at cycle 2, rvalid at cycle 4 -> ls_wbdata=0xFFFFFFFF_FFFFFF80 in the rvalid cycle; ls_stall high cycles 0–3, low at 4.
- SH, addr=0x80000006, sdata=0xBEEF -> mem_we=1, mem_addr=0x80000000, wstrb=0xC0, wdata[63:48]=0xBEEF; completes on rvalid.
- LW, addr=0x80000002 -> ls_misalign=1 one cycle, no mem_req, ls_stall=0.
- LD completing with wb_stall=1 for 3 cycles -> HOLD, ls_stall stays 1, ls_wbdata stable = loaded value, releases on the cycle wb_stall drops.
- Load with mem_ready never asserted, TIMEOUT=255 -> ls_bus_err pulse 255 cycles after REQ entry, ls_stall=0. Then rst=1 mid-REQ on a second load -> next cycle mem_req=0, state IDLE.
